// File: rtl/rr_input_arbiter_if.sv
// rr_input_arbiter_if: bundle of N parallel AXI4-Stream channels packed side by side
interface rr_input_arbiter_if #(
  parameter int N  = 1,
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [N*DW-1:0]   tdata;
  logic [N*DW/8-1:0] tstrb;
  logic [N*UW-1:0]   tuser;
  logic [N-1:0]      tvalid;
  logic [N-1:0]      tlast;
  logic [N-1:0]      tready;
  modport master(output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave(input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rr_input_arbiter.sv
// rr_input_arbiter: packet-granularity round-robin merge of NUM_QUEUES AXI4-Stream queues
module rr_input_arbiter #(
  parameter int NUM_QUEUES         = 5,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int QID_WIDTH          = 3
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  rr_input_arbiter_if.slave    s_axis,
  rr_input_arbiter_if.master   m_axis,
  output logic                 pkt_done,
  output logic [QID_WIDTH-1:0] pkt_src
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  typedef enum logic {IDLE, PKT} state_t;
  state_t               state;
  logic [QID_WIDTH-1:0] grant, last_grant, next_grant;
  logic                 out_free, accept;
  logic [DW-1:0]        data_q [NUM_QUEUES];
  logic [SW-1:0]        strb_q [NUM_QUEUES];
  logic [UW-1:0]        user_q [NUM_QUEUES];
  function automatic logic [QID_WIDTH-1:0] rot(input logic [QID_WIDTH-1:0] base, input int k);
    return QID_WIDTH'((int'(base) + k) % NUM_QUEUES);
  endfunction
  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_slice
    assign data_q[i] = s_axis.tdata[i*DW +: DW];
    assign strb_q[i] = s_axis.tstrb[i*SW +: SW];
    assign user_q[i] = s_axis.tuser[i*UW +: UW];
  end
  // Only the granted queue sees ready, and only when the output register can take a beat
  always_comb begin
    out_free = !m_axis.tvalid[0] || m_axis.tready[0];
    s_axis.tready = (state == PKT && out_free) ? NUM_QUEUES'(1) << grant : '0;
    accept = s_axis.tvalid[grant] && s_axis.tready[grant];
  end
  // Rotating priority starting just after the last completed grant; descending scan so the nearest wins
  always_comb begin
    next_grant = last_grant;
    for (int k = NUM_QUEUES; k >= 1; k--)
      if (s_axis.tvalid[rot(last_grant, k)]) next_grant = rot(last_grant, k);
  end
  // Grant FSM, registered output stage and packet-completion pulse
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= QID_WIDTH'(NUM_QUEUES - 1);
      m_axis.tvalid <= '0;
      m_axis.tlast  <= '0;
      m_axis.tdata  <= '0;
      m_axis.tstrb  <= '0;
      m_axis.tuser  <= '0;
      pkt_done      <= 1'b0;
      pkt_src       <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (out_free) m_axis.tvalid <= accept;
      if (accept) begin
        m_axis.tdata <= data_q[grant];
        m_axis.tstrb <= strb_q[grant];
        m_axis.tuser <= user_q[grant];
        m_axis.tlast <= s_axis.tlast[grant];
      end
      if (state == IDLE) begin
        if (|s_axis.tvalid) begin
          grant <= next_grant;
          state <= PKT;
        end
      end else if (accept && s_axis.tlast[grant]) begin
        last_grant <= grant;
        pkt_done   <= 1'b1;
        pkt_src    <= grant;
        state      <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rr_input_arbiter.sv
// tb_rr_input_arbiter: directed scoreboard bench for rr_input_arbiter
module tb_rr_input_arbiter;
  localparam int NQ = 5;
  localparam int DW = 32;
  localparam int UW = 8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_done;
  logic [2:0] pkt_src;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [32:0] src_q [NQ][$];
  logic [32:0] exp_q[$];
  logic [2:0]  exp_src[$];
  int          beat_cyc[$];
  int          pd_cyc[$];
  int          acc_cyc[$];
  logic [NQ-1:0] acc;
  rr_input_arbiter_if #(.N(NQ), .DW(DW), .UW(UW)) s_if();
  rr_input_arbiter_if #(.N(1), .DW(DW), .UW(UW)) m_if();
  rr_input_arbiter #(.NUM_QUEUES(NQ), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .QID_WIDTH(3)) dut (
    .axi_aclk(clk), .axi_resetn(rst_n), .s_axis(s_if), .m_axis(m_if),
    .pkt_done(pkt_done), .pkt_src(pkt_src));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] user_of(input logic [31:0] d);
    return d[7:0] ^ 8'h5A;
  endfunction
  function automatic logic [3:0] strb_of(input logic [31:0] d);
    return d[3:0] | 4'h8;
  endfunction
  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  function automatic bit busy();
    for (int i = 0; i < NQ; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  // Source model: sample handshakes at negedge, retire accepted beats and present next heads after the edge
  always @(negedge clk) begin
    acc = s_if.tvalid & s_if.tready;
    if (acc != '0) acc_cyc.push_back(cyc);
  end
  initial begin
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tuser  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NQ; i++) begin
        logic [32:0] hd;
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        hd = (src_q[i].size() > 0) ? src_q[i][0] : 33'h0;
        s_if.tvalid[i] = src_q[i].size() > 0;
        s_if.tlast[i]  = hd[32];
        s_if.tdata[i*DW +: DW]   = hd[31:0];
        s_if.tstrb[i*DW/8 +: DW/8] = strb_of(hd[31:0]);
        s_if.tuser[i*UW +: UW]   = user_of(hd[31:0]);
      end
    end
  end
  // Monitor: pop the scoreboard whenever the master side transfers a beat or pulses pkt_done
  always @(negedge clk) begin
    logic [32:0] e;
    logic [2:0]  s;
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      beat_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got unexpected data %h, required no beat", m_if.tdata);
      end else begin
        e = exp_q.pop_front();
        if (m_if.tdata !== e[31:0] || m_if.tlast[0] !== e[32] || m_if.tuser !== user_of(e[31:0]) || m_if.tstrb !== strb_of(e[31:0])) begin
          errors++;
          $display("FAIL beat: got data %h last %b user %h strb %h, required data %h last %b user %h strb %h",
                   m_if.tdata, m_if.tlast[0], m_if.tuser, m_if.tstrb, e[31:0], e[32], user_of(e[31:0]), strb_of(e[31:0]));
        end
      end
    end
    if (pkt_done === 1'b1) begin
      pd_cyc.push_back(cyc);
      checks++;
      if (exp_src.size() == 0) begin
        errors++;
        $display("FAIL pkt_done: got unexpected pulse src %0d, required none", pkt_src);
      end else begin
        s = exp_src.pop_front();
        if (pkt_src !== s || !(m_if.tvalid[0] && m_if.tlast[0])) begin
          errors++;
          $display("FAIL pkt_done: got src %0d tvalid %b tlast %b, required src %0d tvalid 1 tlast 1",
                   pkt_src, m_if.tvalid[0], m_if.tlast[0], s);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input bit ok, input string name, input int got, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask
  task automatic load(input int q, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) src_q[q].push_back({k == n - 1, base + 32'(k)});
  endtask
  task automatic expect_pkt(input int q, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, base + 32'(k)});
    exp_src.push_back(3'(q));
  endtask
  task automatic wait_done(input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || exp_src.size() > 0 || busy()) && n < limit) begin
      step();
      n++;
    end
    chk(n < limit, "drain timeout", n, limit);
    repeat (2) step();
  endtask
  initial begin
    int a0, b0, p0, n, viol;
    int ord[5];
    logic [31:0] snap;
    ord = '{1, 2, 3, 4, 0};
    rst_n = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) step();
    chk(m_if.tvalid[0] === 1'b0, "reset m_tvalid", int'(m_if.tvalid[0]), 0);
    chk(s_if.tready === '0, "reset s_tready", int'(s_if.tready), 0);
    chk(pkt_done === 1'b0 && pkt_src === 3'd0, "reset pkt_done/src", int'({pkt_done, pkt_src}), 0);
    chk(m_if.tdata === '0, "reset m_tdata", int'(m_if.tdata), 0);
    rst_n = 1'b1;
    step();
    // single queue, 3-beat packet
    a0 = acc_cyc.size(); b0 = beat_cyc.size(); p0 = pd_cyc.size();
    load(0, 32'hA0, 3);
    expect_pkt(0, 32'hA0, 3);
    wait_done(50);
    for (int k = 0; k < 3; k++)
      chk(at(beat_cyc, b0 + k) == at(acc_cyc, a0 + k) + 1, "s1 latency", at(beat_cyc, b0 + k), at(acc_cyc, a0 + k) + 1);
    chk(pd_cyc.size() - p0 == 1, "s1 pkt_done count", pd_cyc.size() - p0, 1);
    chk(at(pd_cyc, p0) == at(beat_cyc, b0 + 2), "s1 pkt_done cycle", at(pd_cyc, p0), at(beat_cyc, b0 + 2));
    // all queues, two 2-beat packets each; last_grant is 0 so rotation starts at 1
    p0 = pd_cyc.size();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < NQ; q++) load(q, 32'h100 + 32'(r * 'h40 + q * 'h8), 2);
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 5; j++) expect_pkt(ord[j], 32'h100 + 32'(r * 'h40 + ord[j] * 'h8), 2);
    wait_done(200);
    chk(pd_cyc.size() - p0 == 10, "s2 pkt count", pd_cyc.size() - p0, 10);
    for (int k = 1; k < 10; k++)
      chk(at(pd_cyc, p0 + k) - at(pd_cyc, p0 + k - 1) == 3, "s2 packet spacing", at(pd_cyc, p0 + k) - at(pd_cyc, p0 + k - 1), 3);
    // queue 3 requests while queue 2 is mid-packet
    load(2, 32'h300, 4);
    expect_pkt(2, 32'h300, 4);
    n = 0;
    while (src_q[2].size() > 3 && n < 50) begin step(); n++; end
    chk(n < 50, "s3 start timeout", n, 50);
    load(3, 32'h380, 2);
    expect_pkt(3, 32'h380, 2);
    n = 0; viol = 0;
    while (src_q[2].size() > 0 && n < 50) begin
      if (s_if.tready[3]) viol++;
      step();
      n++;
    end
    chk(viol == 0, "s3 q3 held off", viol, 0);
    wait_done(100);
    // master backpressure for 5 cycles mid-packet
    b0 = beat_cyc.size();
    load(1, 32'h400, 4);
    expect_pkt(1, 32'h400, 4);
    n = 0;
    while (beat_cyc.size() < b0 + 2 && n < 50) begin step(); n++; end
    chk(n < 50, "s4 start timeout", n, 50);
    m_if.tready = 1'b0;
    #1;
    snap = m_if.tdata;
    for (int k = 0; k < 5; k++) begin
      step();
      chk(m_if.tdata === snap && m_if.tvalid[0] === 1'b1, "s4 output frozen", int'(m_if.tdata), int'(snap));
      chk(s_if.tready === '0, "s4 s_tready low", int'(s_if.tready), 0);
    end
    m_if.tready = 1'b1;
    wait_done(100);
    // asynchronous reset mid-packet on queue 1
    b0 = beat_cyc.size();
    load(1, 32'h500, 4);
    expect_pkt(1, 32'h500, 4);
    n = 0;
    while (beat_cyc.size() < b0 + 1 && n < 50) begin step(); n++; end
    chk(n < 50, "s5 start timeout", n, 50);
    #1;
    rst_n = 1'b0;
    #1;
    chk(m_if.tvalid[0] === 1'b0, "s5 async m_tvalid", int'(m_if.tvalid[0]), 0);
    chk(s_if.tready === '0, "s5 async s_tready", int'(s_if.tready), 0);
    chk(pkt_done === 1'b0, "s5 async pkt_done", int'(pkt_done), 0);
    for (int i = 0; i < NQ; i++) src_q[i].delete();
    exp_q.delete();
    exp_src.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    load(1, 32'h580, 2);
    load(0, 32'h5C0, 2);
    expect_pkt(0, 32'h5C0, 2);
    expect_pkt(1, 32'h580, 2);
    wait_done(100);
    // back-to-back single-beat packets on queue 4
    p0 = pd_cyc.size();
    for (int k = 0; k < 4; k++) begin
      load(4, 32'h600 + 32'(k), 1);
      expect_pkt(4, 32'h600 + 32'(k), 1);
    end
    wait_done(100);
    chk(pd_cyc.size() - p0 == 4, "s6 pkt count", pd_cyc.size() - p0, 4);
    for (int k = 1; k < 4; k++)
      chk(at(pd_cyc, p0 + k) - at(pd_cyc, p0 + k - 1) == 2, "s6 packet spacing", at(pd_cyc, p0 + k) - at(pd_cyc, p0 + k - 1), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
